// File: rtl/match_if.sv
// Handshake bundle between a match driver (master) and the match_controller (slave).
// Snitch pulses exist only when SNITCH_CATCH_EN is defined.
interface match_if;
  logic       start;
  logic       pause_toggle;
  logic       goal_a;
  logic       goal_b;
`ifdef SNITCH_CATCH_EN
  logic       snitch_a;
  logic       snitch_b;
`endif
  logic       playing_reg;
  logic [7:0] score_a;
  logic [7:0] score_b;
  logic [7:0] seconds_left;
  logic       game_over;
  logic [1:0] winner;
  logic       score_pulse;

  modport master (
`ifdef SNITCH_CATCH_EN
    output snitch_a, output snitch_b,
`endif
    output start, output pause_toggle, output goal_a, output goal_b,
    input  playing_reg, input score_a, input score_b, input seconds_left,
    input  game_over, input winner, input score_pulse
  );

  modport slave (
`ifdef SNITCH_CATCH_EN
    input  snitch_a, input snitch_b,
`endif
    input  start, input pause_toggle, input goal_a, input goal_b,
    output playing_reg, output score_a, output score_b, output seconds_left,
    output game_over, output winner, output score_pulse
  );
endinterface

// File: rtl/match_controller.sv
// Match timer / scoreboard FSM (IDLE, PLAYING, PAUSED, OVER) with registered outputs.
// Optional feature macro: SNITCH_CATCH_EN (snitch pulses add 150 points and end the match).
module match_controller #(
  parameter int CLK_HZ        = 25000000,
  parameter int MATCH_SECONDS = 60,
  parameter int GOAL_POINTS   = 10
) (
  input  logic    clk,
  input  logic    reset,
  match_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, PLAYING = 2'd1, PAUSED = 2'd2, OVER = 2'd3} state_t;

  localparam int            TW         = $clog2(CLK_HZ);
  localparam logic [TW-1:0] TICK_MAX   = TW'(CLK_HZ - 1);
  localparam logic [7:0]    SECS_INIT  = 8'(MATCH_SECONDS);
  localparam logic [7:0]    GOAL_INC   = 8'(GOAL_POINTS);
  localparam logic [7:0]    SNITCH_INC = 8'd150;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  function automatic logic [1:0] winner_of(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? 2'b01 : ((b > a) ? 2'b10 : 2'b00);
  endfunction

  state_t        state_r, state_s;
  logic [TW-1:0] tick_r, tick_s;
  logic [7:0]    score_a_r, score_a_s, score_b_r, score_b_s, secs_r, secs_s;
  logic [1:0]    winner_r, winner_s;
  logic          playing_r, over_r, pulse_r, pulse_s, caught_s, last_tick_s;

  // Next-state, counter and score computation for the current state and input pulses.
  always_comb begin
    state_s     = state_r;
    tick_s      = tick_r;
    score_a_s   = score_a_r;
    score_b_s   = score_b_r;
    secs_s      = secs_r;
    winner_s    = winner_r;
    pulse_s     = 1'b0;
    caught_s    = 1'b0;
    last_tick_s = 1'b0;
    case (state_r)
      IDLE, OVER: begin
        if (bus.start) begin
          state_s   = PLAYING;
          tick_s    = '0;
          score_a_s = 8'd0;
          score_b_s = 8'd0;
          secs_s    = SECS_INIT;
          winner_s  = 2'b00;
        end else begin
          state_s   = state_r;
        end
      end
      PLAYING: begin
        score_a_s = bus.goal_a ? sat_add(score_a_r, GOAL_INC) : score_a_r;
        score_b_s = bus.goal_b ? sat_add(score_b_r, GOAL_INC) : score_b_r;
`ifdef SNITCH_CATCH_EN
        score_a_s = bus.snitch_a ? sat_add(score_a_s, SNITCH_INC) : score_a_s;
        score_b_s = bus.snitch_b ? sat_add(score_b_s, SNITCH_INC) : score_b_s;
        caught_s  = bus.snitch_a | bus.snitch_b;
`endif
        pulse_s = (score_a_s != score_a_r) || (score_b_s != score_b_r);
        if (tick_r == TICK_MAX) begin
          tick_s      = '0;
          secs_s      = secs_r - 8'd1;
          last_tick_s = (secs_r == 8'd1);
        end else begin
          tick_s      = tick_r + TW'(1'b1);
        end
        // Goals above are already folded in, so the end-of-match winner sees them.
        if (last_tick_s || caught_s) begin
          state_s  = OVER;
          winner_s = winner_of(score_a_s, score_b_s);
        end else if (bus.pause_toggle) begin
          state_s  = PAUSED;
        end else begin
          state_s  = PLAYING;
        end
      end
      PAUSED: begin
        if (bus.pause_toggle) begin
          state_s = PLAYING;
        end else begin
          state_s = PAUSED;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      tick_r    <= '0;
      score_a_r <= 8'd0;
      score_b_r <= 8'd0;
      secs_r    <= SECS_INIT;
      winner_r  <= 2'b00;
      playing_r <= 1'b0;
      over_r    <= 1'b0;
      pulse_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      tick_r    <= tick_s;
      score_a_r <= score_a_s;
      score_b_r <= score_b_s;
      secs_r    <= secs_s;
      winner_r  <= winner_s;
      playing_r <= (state_s == PLAYING);
      over_r    <= (state_s == OVER);
      pulse_r   <= pulse_s;
    end
  end

  assign bus.playing_reg  = playing_r;
  assign bus.score_a      = score_a_r;
  assign bus.score_b      = score_b_r;
  assign bus.seconds_left = secs_r;
  assign bus.game_over    = over_r;
  assign bus.winner       = winner_r;
  assign bus.score_pulse  = pulse_r;
endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: two DUTs (10 and 200 points per goal), a cycle-level
// behavioural model compared every cycle, directed scenarios and a randomized phase.
module tb_match_controller;
  localparam int CLK_HZ        = 4;
  localparam int MATCH_SECONDS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] st = 2'b00, pt = 2'b00, ga = 2'b00, gb = 2'b00;
`ifdef SNITCH_CATCH_EN
  logic [1:0] sa = 2'b00, sb = 2'b00;
`endif
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  match_if bus0 ();
  match_if bus1 ();

  assign bus0.start = st[0];  assign bus0.pause_toggle = pt[0];
  assign bus0.goal_a = ga[0]; assign bus0.goal_b = gb[0];
  assign bus1.start = st[1];  assign bus1.pause_toggle = pt[1];
  assign bus1.goal_a = ga[1]; assign bus1.goal_b = gb[1];
`ifdef SNITCH_CATCH_EN
  assign bus0.snitch_a = sa[0]; assign bus0.snitch_b = sb[0];
  assign bus1.snitch_a = sa[1]; assign bus1.snitch_b = sb[1];
`endif

  // Packed view: {playing, game_over, winner[1:0], pulse, score_a, score_b, seconds_left}
  logic [28:0] got [2];
  assign got[0] = {bus0.playing_reg, bus0.game_over, bus0.winner, bus0.score_pulse,
                   bus0.score_a, bus0.score_b, bus0.seconds_left};
  assign got[1] = {bus1.playing_reg, bus1.game_over, bus1.winner, bus1.score_pulse,
                   bus1.score_a, bus1.score_b, bus1.seconds_left};

  match_controller #(.CLK_HZ(CLK_HZ), .MATCH_SECONDS(MATCH_SECONDS), .GOAL_POINTS(10))
    dut0 (.clk(clk), .reset(rst), .bus(bus0));
  match_controller #(.CLK_HZ(CLK_HZ), .MATCH_SECONDS(MATCH_SECONDS), .GOAL_POINTS(200))
    dut1 (.clk(clk), .reset(rst), .bus(bus1));

  // Model: mode 0 idle, 1 playing, 2 paused, 3 over; time kept as elapsed playing cycles.
  int m_mode [2], m_played [2], m_a [2], m_b [2], m_win [2];
  bit m_pulse [2];

  function automatic int gp_of(int i);
    return (i == 0) ? 10 : 200;
  endfunction

  function automatic int sat(int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int cmp(int a, int b);
    return (a > b) ? 1 : ((b > a) ? 2 : 0);
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int na, nb;
    bit ended;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_mode[i] <= 0; m_played[i] <= 0; m_a[i] <= 0; m_b[i] <= 0;
        m_win[i] <= 0;  m_pulse[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_pulse[i] <= 1'b0;
        case (m_mode[i])
          0, 3: if (st[i]) begin
            m_mode[i] <= 1; m_played[i] <= 0; m_a[i] <= 0; m_b[i] <= 0; m_win[i] <= 0;
          end
          1: begin
            na = sat(m_a[i] + (ga[i] ? gp_of(i) : 0));
            nb = sat(m_b[i] + (gb[i] ? gp_of(i) : 0));
            ended = (m_played[i] + 1 == MATCH_SECONDS * CLK_HZ);
`ifdef SNITCH_CATCH_EN
            na = sat(na + (sa[i] ? 150 : 0));
            nb = sat(nb + (sb[i] ? 150 : 0));
            ended = ended || sa[i] || sb[i];
`endif
            m_a[i] <= na;
            m_b[i] <= nb;
            m_pulse[i] <= (na != m_a[i]) || (nb != m_b[i]);
            m_played[i] <= m_played[i] + 1;
            if (ended) begin
              m_mode[i] <= 3;
              m_win[i]  <= cmp(na, nb);
            end else if (pt[i]) begin
              m_mode[i] <= 2;
            end
          end
          2: if (pt[i]) m_mode[i] <= 1;
          default: ;
        endcase
      end
    end
  end

  function automatic logic [28:0] expected(int i);
    logic [7:0] secs;
    secs = 8'(MATCH_SECONDS - m_played[i] / CLK_HZ);
    return {m_mode[i] == 1, m_mode[i] == 3, 2'(m_win[i]), m_pulse[i],
            8'(m_a[i]), 8'(m_b[i]), secs};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++)
        check($sformatf("dut%0d cycle outputs", i), 32'(got[i]), 32'(expected(i)));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_start(int i);
    st[i] = 1'b1; step(); st[i] = 1'b0;
  endtask

  task automatic pulse_pause(int i);
    pt[i] = 1'b1; step(); pt[i] = 1'b0;
  endtask

  task automatic pulse_goal(int i, bit a, bit b);
    ga[i] = a; gb[i] = b; step(); ga[i] = 1'b0; gb[i] = 1'b0;
  endtask

  task automatic wait_over(int i, output int n);
    n = 0;
    while (!got[i][27] && n < 60) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n, cnt;
    repeat (3) step();
    rst = 1'b0;
    check("reset state", 32'(got[0]), 32'({1'b0, 1'b0, 2'b00, 1'b0, 8'd0, 8'd0, 8'd3}));

    // Plain match runs out on the timer.
    pulse_start(0);
    check("start playing_reg", 32'(bus0.playing_reg), 32'd1);
    wait_over(0, n);
    check("timer cycles to over", 32'(n), 32'd12);
    check("timer seconds_left", 32'(bus0.seconds_left), 32'd0);
    check("timer winner", 32'(bus0.winner), 32'd0);
    check("model pin over", 32'(expected(0)), 32'({1'b0, 1'b1, 2'b00, 1'b0, 8'd0, 8'd0, 8'd0}));

    // Two goals for A, one for B, counting score pulses.
    pulse_start(0);
    cnt = 0; n = 0;
    while (!bus0.game_over && n < 40) begin
      ga[0] = (n == 1 || n == 3); gb[0] = (n == 5);
      step();
      ga[0] = 1'b0; gb[0] = 1'b0;
      cnt += int'(bus0.score_pulse);
      n++;
    end
    check("goals score_a", 32'(bus0.score_a), 32'd20);
    check("goals score_b", 32'(bus0.score_b), 32'd10);
    check("goals pulse count", 32'(cnt), 32'd3);
    check("goals winner", 32'(bus0.winner), 32'd1);

    // Pause after five playing cycles, hold twenty, resume.
    pulse_start(0);
    repeat (5) step();
    pulse_pause(0);
    check("paused playing_reg", 32'(bus0.playing_reg), 32'd0);
    repeat (20) step();
    check("paused seconds_left", 32'(bus0.seconds_left), 32'd2);
    pulse_pause(0);
    check("resumed playing_reg", 32'(bus0.playing_reg), 32'd1);
    wait_over(0, n);
    check("resume cycles to over", 32'(n), 32'd6);

    // Saturation on the 200-point DUT.
    pulse_start(1);
    pulse_goal(1, 1'b0, 1'b1);
    check("sat first goal", 32'({bus1.score_b, bus1.score_pulse}), 32'({8'd200, 1'b1}));
    pulse_goal(1, 1'b0, 1'b1);
    check("sat second goal", 32'({bus1.score_b, bus1.score_pulse}), 32'({8'd255, 1'b1}));
    pulse_goal(1, 1'b0, 1'b1);
    check("sat third goal", 32'({bus1.score_b, bus1.score_pulse}), 32'({8'd255, 1'b0}));

    // Both teams score on the final tick.
    pulse_start(0);
    repeat (11) step();
    pulse_goal(0, 1'b1, 1'b1);
    check("final tick scores", 32'({bus0.score_a, bus0.score_b}), 32'({8'd10, 8'd10}));
    check("final tick over", 32'({bus0.game_over, bus0.winner}), 32'({1'b1, 2'b00}));

    // Asynchronous reset in the middle of a match.
    pulse_start(0);
    repeat (3) pulse_goal(0, 1'b1, 1'b0);
    check("pre-reset score_a", 32'(bus0.score_a), 32'd30);
    #2 rst = 1'b1;
    #1 check("async reset outputs", 32'({bus0.playing_reg, bus0.score_a, bus0.seconds_left}),
             32'({1'b0, 8'd0, 8'd3}));
    step();
    rst = 1'b0;
    step();

`ifdef SNITCH_CATCH_EN
    pulse_start(0);
    sb[0] = 1'b1; step(); sb[0] = 1'b0;
    check("snitch score_b", 32'(bus0.score_b), 32'd150);
    check("snitch over", 32'({bus0.game_over, bus0.winner}), 32'({1'b1, 2'b10}));
`endif

    // Randomized traffic on both DUTs, with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        st[i] = ($urandom_range(0, 29) == 0);
        pt[i] = ($urandom_range(0, 11) == 0);
        ga[i] = ($urandom_range(0, 3) == 0);
        gb[i] = ($urandom_range(0, 3) == 0);
`ifdef SNITCH_CATCH_EN
        sa[i] = ($urandom_range(0, 79) == 0);
        sb[i] = ($urandom_range(0, 79) == 0);
`endif
      end
      rst = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0; st = 2'b00; pt = 2'b00; ga = 2'b00; gb = 2'b00;
`ifdef SNITCH_CATCH_EN
    sa = 2'b00; sb = 2'b00;
`endif
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
